// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It keeps at most one instruction-memory request in
// flight and fills the IF/ID register that feeds decode. A one-entry skid
// register catches a response that arrives while decode is stalled (load-use).
// EX-stage redirects flush IF/ID. A redirect that lands while a request is
// still in flight waits in DRAIN until that response returns, and the response
// is dropped. halt is sticky: any in-flight request finishes, its response is
// discarded, and fetching then stops until reset.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   lu          load-use stall from decode; keeps IF/ID unchanged
//   JB          EX redirect (jump, jr, taken branch)
//   new_pc      redirect target; bits [1:0] are ignored
//   halt        stop fetching (sticky)
//   imem_req    instruction memory request (registered)
//   imem_addr   request word address (registered)
//   imem_ack    response strobe; imem_rdata is valid in the same cycle
//   imem_rdata  fetched instruction
//   out_pc      IF/ID: pc of the held instruction
//   out_pc_4    IF/ID: out_pc + 4
//   out_ir      IF/ID: instruction word
//   out_valid   IF/ID holds a live instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lu,
    input  logic        JB,
    input  logic [31:0] new_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_4,
    output logic [31:0] out_ir,
    output logic        out_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [31:0] pc_r;
    logic [31:0] req_addr_r;
    logic        imem_req_r;
    logic        halt_r;
    logic [31:0] skid_ir_r;
    logic [31:0] out_pc_r;
    logic [31:0] out_pc_4_r;
    logic [31:0] out_ir_r;
    logic        out_valid_r;

    logic [31:0] next_pc_s;
    logic [31:0] next_req_addr_s;
    logic        next_imem_req_s;
    logic [31:0] next_skid_ir_s;
    logic [31:0] next_out_pc_s;
    logic [31:0] next_out_pc_4_s;
    logic [31:0] next_out_ir_s;
    logic        next_out_valid_s;

    logic        ack_s;
    logic        stop_s;
    logic        slot_free_s;
    logic        pending_s;
    logic [31:0] target_s;
    logic [31:0] req_inc_s;

    // Ack only counts while a request is actually presented; stop folds the
    // live halt input into the sticky flag so halt acts in its own cycle.
    always_comb begin
        ack_s       = imem_ack & imem_req_r;
        stop_s      = halt | halt_r;
        slot_free_s = ~out_valid_r | ~lu;
        pending_s   = imem_req_r & ~(imem_ack & imem_req_r);
        target_s    = new_pc & 32'hFFFF_FFFC;
        req_inc_s   = req_addr_r + 32'd4;
    end

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        next_state_s     = state_r;
        next_pc_s        = pc_r;
        next_req_addr_s  = req_addr_r;
        next_skid_ir_s   = skid_ir_r;
        next_out_pc_s    = out_pc_r;
        next_out_pc_4_s  = out_pc_4_r;
        next_out_ir_s    = out_ir_r;
        next_out_valid_s = out_valid_r;

        case (state_r)
            FETCH: begin
                if (stop_s) begin
                    // Let an in-flight request finish before parking.
                    if (pending_s) begin
                        next_state_s = DRAIN;
                    end else begin
                        next_state_s = HALT;
                    end
                end else if (JB) begin
                    next_out_valid_s = 1'b0;
                    next_pc_s        = target_s;
                    if (pending_s) begin
                        next_state_s = DRAIN;
                    end else begin
                        // Response (if any) this cycle is dropped; go straight to target.
                        next_req_addr_s = target_s;
                    end
                end else if (ack_s) begin
                    if (slot_free_s) begin
                        next_out_ir_s    = imem_rdata;
                        next_out_pc_s    = req_addr_r;
                        next_out_pc_4_s  = req_inc_s;
                        next_out_valid_s = 1'b1;
                        next_pc_s        = req_inc_s;
                        next_req_addr_s  = req_inc_s;
                    end else begin
                        // Decode is stalled: park the word; req_addr keeps its pc.
                        next_skid_ir_s = imem_rdata;
                        next_state_s   = HOLD;
                    end
                end else if (!lu) begin
                    // Decode consumed IF/ID and nothing new arrived: bubble.
                    next_out_valid_s = 1'b0;
                end else begin
                    next_out_valid_s = out_valid_r;
                end
            end

            HOLD: begin
                if (stop_s) begin
                    next_skid_ir_s = 32'd0;
                    next_state_s   = HALT;
                end else if (JB) begin
                    next_skid_ir_s   = 32'd0;
                    next_out_valid_s = 1'b0;
                    next_pc_s        = target_s;
                    next_req_addr_s  = target_s;
                    next_state_s     = FETCH;
                end else if (!lu) begin
                    next_out_ir_s    = skid_ir_r;
                    next_out_pc_s    = req_addr_r;
                    next_out_pc_4_s  = req_inc_s;
                    next_out_valid_s = 1'b1;
                    next_pc_s        = req_inc_s;
                    next_req_addr_s  = req_inc_s;
                    next_state_s     = FETCH;
                end else begin
                    next_state_s = HOLD;
                end
            end

            DRAIN: begin
                if (stop_s) begin
                    if (ack_s) begin
                        next_state_s = HALT;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end else if (JB) begin
                    // Latest redirect wins; the stored target lives in pc_r.
                    next_out_valid_s = 1'b0;
                    next_pc_s        = target_s;
                    if (ack_s) begin
                        next_req_addr_s = target_s;
                        next_state_s    = FETCH;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end else if (ack_s) begin
                    next_req_addr_s = pc_r;
                    next_state_s    = FETCH;
                end else begin
                    next_state_s = DRAIN;
                end
            end

            HALT: begin
                next_state_s = HALT;
            end

            default: begin
                next_state_s = FETCH;
            end
        endcase

        next_imem_req_s = (next_state_s == FETCH) || (next_state_s == DRAIN);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request, skid and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            req_addr_r  <= RESET_PC;
            imem_req_r  <= 1'b0;
            halt_r      <= 1'b0;
            skid_ir_r   <= 32'd0;
            out_pc_r    <= 32'd0;
            out_pc_4_r  <= 32'd0;
            out_ir_r    <= 32'd0;
            out_valid_r <= 1'b0;
        end else begin
            pc_r        <= next_pc_s;
            req_addr_r  <= next_req_addr_s;
            imem_req_r  <= next_imem_req_s;
            halt_r      <= stop_s;
            skid_ir_r   <= next_skid_ir_s;
            out_pc_r    <= next_out_pc_s;
            out_pc_4_r  <= next_out_pc_4_s;
            out_ir_r    <= next_out_ir_s;
            out_valid_r <= next_out_valid_s;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = req_addr_r;
    assign out_pc    = out_pc_r;
    assign out_pc_4  = out_pc_4_r;
    assign out_ir    = out_ir_r;
    assign out_valid = out_valid_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lu  input  1  load-use stall; holds the IF/ID outputs.
REQ-005 SHALL have port JB  input  1  EX-stage redirect (jump, jr or taken branch).
REQ-006 SHALL have port new_pc  input  32  redirect target, valid when JB=1.
REQ-007 SHALL have port halt  input  1  stop fetching; sticky until reset.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  32  request word address.
REQ-010 SHALL have port imem_ack  input  1  response strobe; imem_rdata valid in the same cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-012 SHALL have ports out_pc, out_pc_4, out_ir  output  32 each  IF/ID contents for decode.
REQ-013 SHALL have port out_valid  output  1  IF/ID holds a live instruction.

Function
REQ-014 SHALL implement states FETCH, HOLD, DRAIN and HALT, with at most one request outstanding.
REQ-015 FETCH: imem_req=1 and imem_addr=req_addr; req_addr and imem_req SHALL stay stable until imem_ack.
REQ-016 The IF/ID slot is free when out_valid=0 or lu=0.
REQ-017 FETCH with ack, JB=0 and slot free: the outputs SHALL latch out_ir=rdata, out_pc=req_addr, out_pc_4=req_addr+4 and out_valid=1; pc SHALL become req_addr+4; the next request SHALL issue the following cycle.
REQ-018 FETCH with ack, JB=0 and slot not free: rdata SHALL go into the skid register; the state SHALL become HOLD; imem_req SHALL be 0.
REQ-019 HOLD with lu=0: the skid contents SHALL move to IF/ID; pc SHALL advance by 4; the state SHALL return to FETCH.
REQ-020 JB=1, any state except HALT: out_valid SHALL be 0 next cycle (flush) and pc SHALL become new_pc; JB SHALL take priority over lu.
REQ-021 JB in FETCH with ack in the same cycle: rdata SHALL be discarded; the next request SHALL go to new_pc; the state SHALL stay FETCH.
REQ-022 JB in FETCH without ack: the state SHALL go to DRAIN; the old request SHALL be held until ack; the response SHALL be discarded; the state SHALL then become FETCH at the stored new_pc.
REQ-023 JB in DRAIN: the stored target SHALL be overwritten by the latest new_pc.
REQ-024 JB in HOLD: the skid contents SHALL be dropped; the state SHALL become FETCH at new_pc.
REQ-025 halt=1: no new request SHALL issue; any outstanding request SHALL complete and be discarded; the state SHALL become HALT, with imem_req=0 and IF/ID held.
REQ-026 HALT SHALL remain until reset; halt SHALL take priority over JB.
REQ-027 lu=1 with out_valid=1: out_pc, out_pc_4, out_ir and out_valid SHALL hold unchanged.
REQ-028 PC arithmetic SHALL be unsigned 32-bit; pc+4 SHALL wrap from 32'hFFFF_FFFC to 0.
REQ-029 Bits [1:0] of pc, req_addr and out_pc SHALL always be 0; new_pc[1:0] SHALL be forced to 0.

Reset
REQ-030 While rst_n=0: state=FETCH, pc=req_addr=RESET_PC, out_valid=0, out_pc=out_pc_4=out_ir=0, skid cleared, imem_req=0.
REQ-031 After rst_n rises, the first request SHALL issue on the first rising edge.
REQ-032 Reset asserted mid-request SHALL abandon the request immediately; an ack arriving during reset SHALL be ignored.

Verification
REQ-033 Zero-wait ack every cycle, no stall -> out_pc sequence 0,4,8,12 on consecutive cycles with out_valid=1 and out_pc_4=out_pc+4.
REQ-034 lu=1 for 3 cycles while the ack for addr 8 arrives -> IF/ID holds pc 4; HOLD entered; pc 8 presented the cycle after lu falls; no request issued during HOLD.
REQ-035 JB=1 with new_pc=0x0000_0100 and no ack pending, ack 2 cycles later -> DRAIN; stale data never reaches IF/ID; next imem_addr=0x100; out_valid=0 until the 0x100 instruction returns.
REQ-036 JB, lu and ack in the same cycle -> flush wins: out_valid=0; data dropped; next imem_addr=new_pc.
REQ-037 halt=1 during an outstanding request -> the response is discarded, imem_req stays 0 forever, JB pulses are ignored, and only rst_n recovers to RESET_PC.
REQ-038 pc=0xFFFF_FFFC fetched -> out_pc_4=0 and the next imem_addr=0.
